logic_op_pipe: RTL and testbench

Two-stage pipelined bitwise logic unit that sits directly upstream of the single-gate primitives' consumers. Each transaction carries two WIDTH-bit operands and an opcode that selects one of the five gate functions: NOT, OR, AND, NAND, NOR. The block registers the operands, computes the selected function and holds the result in a registered output stage. Valid/ready handshakes on both sides give full backpressure. A wrapping transaction counter and an illegal-opcode flag support bring-up and debug.

---
 rtl/logic_op_pipe.sv | 102 ++++++++++
 tb/tb_logic_op_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_pipe.sv
// Two-stage valid/ready bitwise logic unit (NOT/OR/AND/NAND/NOR) with an
// illegal-opcode flag and a wrapping count of results consumed downstream.

module logic_op_lane (
  input  logic       a_i,
  input  logic       b_i,
  input  logic [2:0] op_i,
  output logic       y_o
);
  always_comb begin
    y_o = 1'b0;
    case (op_i)
      3'd0:    y_o = ~a_i;
      3'd1:    y_o = a_i | b_i;
      3'd2:    y_o = a_i & b_i;
      3'd3:    y_o = ~(a_i & b_i);
      3'd4:    y_o = ~(a_i | b_i);
      default: y_o = 1'b0;
    endcase
  end
endmodule

module logic_op_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             err,
  output logic [CNT_W-1:0] done_cnt
);
  localparam logic [2:0] OP_LAST_LEGAL = 3'd4;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [2:0]       s1_op_q;
  logic             out_valid_q, err_q;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] done_cnt_q;
  logic             adv1, adv2, err_d;

  // Each result bit depends only on the same bit of the operands.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic_op_lane u_lane (
      .a_i  (s1_a_q[i]),
      .b_i  (s1_b_q[i]),
      .op_i (s1_op_q),
      .y_o  (y_d[i])
    );
  end

  assign err_d = (s1_op_q > OP_LAST_LEGAL);

  assign adv2 = !out_valid_q || out_ready;
  assign adv1 = !s1_valid_q || adv2;
  // Held low during reset so nothing is accepted into a pipe being cleared.
  assign in_ready = adv1 && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      err_q       <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      if (adv1) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_a_q  <= a;
          s1_b_q  <= b;
          s1_op_q <= op;
        end
      end
      if (adv2) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          y_q   <= y_d;
          err_q <= err_d;
        end
      end
      if (out_valid_q && out_ready)
        done_cnt_q <= done_cnt_q + 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign err       = err_q;
  assign done_cnt  = done_cnt_q;
endmodule

// File: tb/tb_logic_op_pipe.sv
// Randomized and directed bench for logic_op_pipe against a queue reference model.

module tb_logic_op_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [7:0]  a, b;
  logic [2:0]  op;
  logic        in_ready, out_valid, err;
  logic [7:0]  y;
  logic [15:0] done_cnt;
  logic        in_ready4, out_valid4, err4;
  logic [7:0]  y4;
  logic [3:0]  done_cnt4;

  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .err(err), .done_cnt(done_cnt)
  );

  logic_op_pipe #(.WIDTH(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .op(op), .out_valid(out_valid4), .out_ready(out_ready),
    .y(y4), .err(err4), .done_cnt(done_cnt4)
  );

  typedef struct { logic [7:0] y; logic err; int cyc; } item_t;
  item_t      q[$];
  logic [8:0] obs[$];
  int n_chk = 0, n_err = 0;
  int ncyc = 0, ndone = 0, nacc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  // Result as defined by the opcode table: {err, y}
  function automatic logic [8:0] ref_f(input logic [7:0] ra, input logic [7:0] rb,
                                       input logic [2:0] rop);
    case (rop)
      3'd0:    return {1'b0, 8'hFF ^ ra};
      3'd1:    return {1'b0, ra | rb};
      3'd2:    return {1'b0, ra & rb};
      3'd3:    return {1'b0, 8'hFF ^ (ra & rb)};
      3'd4:    return {1'b0, 8'hFF ^ (ra | rb)};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  // One clock: check at negedge, advance the model at posedge, return at posedge+1.
  task automatic step();
    logic of, inf;
    logic [8:0] r, seen;
    of = 1'b0; inf = 1'b0; seen = '0;
    @(negedge clk);
    if (rst) begin
      chk("in_ready_in_rst", in_ready, 1'b0);
    end else begin
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      chk("out_valid", out_valid, (q.size() > 0) && (q[0].cyc < ncyc));
      if (out_valid && q.size() > 0) begin
        chk("y", y, q[0].y);
        chk("err", err, q[0].err);
      end
      chk("done_cnt", done_cnt, ndone[15:0]);
      chk("done_cnt4", done_cnt4, ndone[3:0]);
      of   = out_valid && out_ready;
      inf  = in_valid && in_ready;
      seen = {err, y};
    end
    r = ref_f(a, b, op);
    @(posedge clk);
    ncyc++;
    if (rst) begin
      q.delete();
      ndone = 0;
    end else begin
      if (of && q.size() > 0) begin
        obs.push_back(seen);
        void'(q.pop_front());
        ndone++;
      end
      if (inf) begin
        q.push_back('{y: r[7:0], err: r[8], cyc: ncyc});
        nacc++;
      end
    end
    #1;
  endtask

  task automatic drain(input int budget);
    int k;
    in_valid = 1'b0; out_ready = 1'b1; k = 0;
    while (q.size() > 0 && k < budget) begin step(); k++; end
    chk("drain_timeout", q.size(), 0);
  endtask

  logic [7:0] dir_exp [5];
  logic [7:0] y_hold;
  int acc0;

  initial begin
    dir_exp[0] = 8'h5A; dir_exp[1] = 8'hAF; dir_exp[2] = 8'h05;
    dir_exp[3] = 8'hFA; dir_exp[4] = 8'h50;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_y", y, 8'h00);
    chk("rst_err", err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Directed: each legal opcode on A5/0F back to back
    out_ready = 1'b1; obs.delete();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'hA5; b = 8'h0F; op = 3'(i);
      step();
    end
    drain(10);
    chk("dir_count", obs.size(), 5);
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      chk("dir_y", obs[i][7:0], dir_exp[i]);
      chk("dir_err", obs[i][8], 1'b0);
    end
    chk("dir_done", done_cnt, 16'd5);

    // Illegal opcode
    obs.delete();
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 3'd6;
    step();
    drain(10);
    chk("ill_count", obs.size(), 1);
    if (obs.size() > 0) chk("ill_res", obs[0], 9'h100);
    chk("ill_done", done_cnt, 16'd6);

    // Backpressure: exactly two accepted, outputs held stable
    out_ready = 1'b0; in_valid = 1'b1; acc0 = nacc;
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 4));
      step();
      if (i == 2) y_hold = y;
      if (i > 2) chk("stall_y_stable", y, y_hold);
    end
    chk("stall_accepted", nacc - acc0, 2);
    obs.delete();
    drain(10);
    chk("stall_out", obs.size(), 2);

    // Randomized handshakes
    for (int i = 0; i < 1000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
      step();
    end
    drain(10);
    chk("rand_accounting", ndone, nacc);

    // Reset with two in flight
    out_ready = 1'b0; in_valid = 1'b1;
    step(); step();
    chk("pre_rst_full", q.size(), 2);
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_y", y, 8'h00);
    chk("mid_rst_done", done_cnt, 16'd0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Counter wrap on the narrow instance
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
      step();
    end
    drain(10);
    chk("wrap_done4", done_cnt4, 4'd1);
    chk("wrap_done16", done_cnt, 16'd17);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end
endmodule
